pc_predict_unit: RTL and testbench

- Parametrised fetch-PC generator for the pipelined MIPS core. Successor to the combinational next-PC mux.
- Owns the PC register and a direct-mapped branch target buffer (BTB) that predicts F-stage redirects.
- Resolves jumps and branches from D stage, flushes on mispredict, and takes exception/ERET redirects.

---
 rtl/pc_predict_unit.sv | 192 +++++++++++++++++++
 tb/tb_pc_predict_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : pc_predict_unit
// Brief    : Fetch-PC register with a direct-mapped BTB, D-stage branch/jump
//            resolution, mispredict flush and exception/ERET redirects.
//            Define PC_PERF_CNT_EN to add branch/mispredict counters.
// Revision : 1.0  initial release
//============================================================================
module pc_predict_unit #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
   parameter int unsigned      BTB_DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_pc,
   input  logic [2:0]       d_type,
   input  logic [25:0]      d_imm26,
   input  logic [15:0]      d_imm16,
   input  logic [WIDTH-1:0] d_reg,
   input  logic             d_zero,
   input  logic             d_pred_taken,
   input  logic [WIDTH-1:0] d_pred_target,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc_o,
   output logic             pred_taken_o,
   output logic [WIDTH-1:0] pred_target_o,
   output logic             flush_o
`ifdef PC_PERF_CNT_EN
   ,
   output logic [31:0]      br_cnt_o,
   output logic [31:0]      mispred_cnt_o
`endif
);

   localparam int unsigned      c_idx_w  = $clog2(BTB_DEPTH);
   localparam int unsigned      c_tag_w  = WIDTH - c_idx_w - 2;
   localparam logic [WIDTH-1:0] c_pc_inc = WIDTH'(4);

   localparam logic [2:0] c_type_seq = 3'b000;
   localparam logic [2:0] c_type_j   = 3'b001;
   localparam logic [2:0] c_type_jr  = 3'b010;
   localparam logic [2:0] c_type_beq = 3'b011;

   logic [WIDTH-1:0]     r_pc;
   logic [BTB_DEPTH-1:0] r_btb_vld;
   logic [c_tag_w-1:0]   r_btb_tag [BTB_DEPTH];
   logic [WIDTH-1:0]     r_btb_tgt [BTB_DEPTH];

   logic [c_idx_w-1:0]   w_f_idx;
   logic [c_tag_w-1:0]   w_f_tag;
   logic                 w_f_hit;
   logic [c_idx_w-1:0]   w_d_idx;
   logic [c_tag_w-1:0]   w_d_tag;
   logic                 w_d_hit;

   logic [WIDTH-1:0]     w_seq_pc;
   logic [WIDTH-1:0]     w_br_off;
   logic [WIDTH-1:0]     w_jmp_tgt;
   logic                 w_taken;
   logic [WIDTH-1:0]     w_target;
   logic [WIDTH-1:0]     w_redirect;
   logic                 w_mispred;
   logic                 w_upd;
   logic                 w_btb_wr;
   logic                 w_btb_inv;
   logic [WIDTH-1:0]     w_next_pc;

   // Fetch-side lookup
   assign w_f_idx       = r_pc[c_idx_w+1:2];
   assign w_f_tag       = r_pc[WIDTH-1:c_idx_w+2];
   assign w_f_hit       = r_btb_vld[w_f_idx] && (r_btb_tag[w_f_idx] == w_f_tag);
   assign pc_o          = r_pc;
   assign pred_taken_o  = w_f_hit;
   assign pred_target_o = w_f_hit ? r_btb_tgt[w_f_idx] : '0;

   // Decode-side lookup, used to invalidate stale entries on not-taken branches
   assign w_d_idx = d_pc[c_idx_w+1:2];
   assign w_d_tag = d_pc[WIDTH-1:c_idx_w+2];
   assign w_d_hit = r_btb_vld[w_d_idx] && (r_btb_tag[w_d_idx] == w_d_tag);

   assign w_seq_pc  = d_pc + c_pc_inc;
   assign w_br_off  = {{(WIDTH-18){d_imm16[15]}}, d_imm16, 2'b00};
   assign w_jmp_tgt = {d_pc[WIDTH-1:28], d_imm26, 2'b00};

   always_comb begin
      w_taken  = 1'b0;
      w_target = w_seq_pc;
      case (d_type)
         c_type_j: begin
            w_taken  = 1'b1;
            w_target = w_jmp_tgt;
         end
         c_type_jr: begin
            w_taken  = 1'b1;
            w_target = d_reg;
         end
         c_type_beq: begin
            w_taken  = d_zero;
            w_target = w_seq_pc + w_br_off;
         end
         default: begin
            w_taken  = 1'b0;
            w_target = w_seq_pc;
         end
      endcase
   end

   assign w_redirect = w_taken ? w_target : w_seq_pc;
   assign w_mispred  = d_valid &&
                       ((w_taken != d_pred_taken) ||
                        (w_taken && (d_pred_target != w_target)));
   assign flush_o    = exc_req | eret_req | w_mispred;

   always_comb begin
      w_next_pc = r_pc + c_pc_inc;
      if (exc_req) begin
         w_next_pc = EXC_VEC;
      end else if (eret_req) begin
         w_next_pc = epc;
      end else if (w_mispred) begin
         w_next_pc = w_redirect;
      end else if (stall_i) begin
         w_next_pc = r_pc;
      end else if (w_f_hit) begin
         w_next_pc = r_btb_tgt[w_f_idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   // Resolved control transfers train the BTB regardless of concurrent redirects
   assign w_upd     = d_valid && (d_type != c_type_seq);
   assign w_btb_wr  = w_upd && w_taken;
   assign w_btb_inv = w_upd && !w_taken && w_d_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btb_vld <= '0;
      end else if (w_btb_wr) begin
         r_btb_vld[w_d_idx] <= 1'b1;
      end else if (w_btb_inv) begin
         r_btb_vld[w_d_idx] <= 1'b0;
      end
   end

   // Tag/target payload is qualified by the valid bits, so it needs no reset
   always_ff @(posedge clk) begin
      if (w_btb_wr) begin
         r_btb_tag[w_d_idx] <= w_d_tag;
         r_btb_tgt[w_d_idx] <= w_target;
      end
   end

`ifdef PC_PERF_CNT_EN
   logic [31:0] r_br_cnt;
   logic [31:0] r_mispred_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_br_cnt      <= '0;
         r_mispred_cnt <= '0;
      end else begin
         if (w_upd && (r_br_cnt != 32'hFFFF_FFFF)) begin
            r_br_cnt <= r_br_cnt + 32'd1;
         end
         if (w_mispred && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
         end
      end
   end

   assign br_cnt_o      = r_br_cnt;
   assign mispred_cnt_o = r_mispred_cnt;
`else
   // Counter hardware is not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_predict_unit.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_pc_predict_unit
// Brief    : Scoreboard bench for pc_predict_unit against a behavioural model.
// Revision : 1.0  initial release
//============================================================================
module tb_pc_predict_unit;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;
   localparam int          DEPTH  = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_i = 1'b0;
   logic        d_valid = 1'b0;
   logic [31:0] d_pc = '0;
   logic [2:0]  d_type = '0;
   logic [25:0] d_imm26 = '0;
   logic [15:0] d_imm16 = '0;
   logic [31:0] d_reg = '0;
   logic        d_zero = 1'b0;
   logic        d_pred_taken = 1'b0;
   logic [31:0] d_pred_target = '0;
   logic        exc_req = 1'b0;
   logic        eret_req = 1'b0;
   logic [31:0] epc = '0;
   logic [31:0] pc_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        flush_o;
`ifdef PC_PERF_CNT_EN
   logic [31:0] br_cnt_o;
   logic [31:0] mispred_cnt_o;
`endif

   pc_predict_unit #(
      .WIDTH     (32),
      .RESET_PC  (RST_PC),
      .EXC_VEC   (EXC_PC),
      .BTB_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .d_valid       (d_valid),
      .d_pc          (d_pc),
      .d_type        (d_type),
      .d_imm26       (d_imm26),
      .d_imm16       (d_imm16),
      .d_reg         (d_reg),
      .d_zero        (d_zero),
      .d_pred_taken  (d_pred_taken),
      .d_pred_target (d_pred_target),
      .exc_req       (exc_req),
      .eret_req      (eret_req),
      .epc           (epc),
      .pc_o          (pc_o),
      .pred_taken_o  (pred_taken_o),
      .pred_target_o (pred_target_o),
      .flush_o       (flush_o)
`ifdef PC_PERF_CNT_EN
      ,
      .br_cnt_o      (br_cnt_o),
      .mispred_cnt_o (mispred_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural model: each slot remembers the word address of the branch it holds
   bit          m_vld  [DEPTH];
   logic [29:0] m_word [DEPTH];
   logic [31:0] m_tgt  [DEPTH];
   logic [31:0] m_pc;
   longint      m_br;
   longint      m_mis;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] ptgt;
      logic        fl;
      longint      bc;
      longint      mc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic int slot(logic [31:0] a);
      return int'((a >> 2) % 32'(DEPTH));
   endfunction

   function automatic bit m_hit(logic [31:0] a);
      return m_vld[slot(a)] && (m_word[slot(a)] == a[31:2]);
   endfunction

   task automatic apply();
      exp_t        e;
      bit          taken;
      bit          mis;
      logic [31:0] tgt;
      logic [31:0] nxt;
      int          s;
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) m_vld[k] = 1'b0;
         m_pc  = RST_PC;
         m_br  = 0;
         m_mis = 0;
      end
      e.pc   = m_pc;
      e.pt   = m_hit(m_pc);
      e.ptgt = e.pt ? m_tgt[slot(m_pc)] : 32'h0;
      e.bc   = m_br;
      e.mc   = m_mis;
      taken  = 1'b0;
      tgt    = d_pc + 32'd4;
      if (d_type == 3'd1) begin
         taken = 1'b1;
         tgt   = (d_pc & 32'hF000_0000) | (32'(d_imm26) << 2);
      end else if (d_type == 3'd2) begin
         taken = 1'b1;
         tgt   = d_reg;
      end else if (d_type == 3'd3) begin
         s     = int'($signed(d_imm16));
         taken = d_zero;
         tgt   = d_pc + 32'd4 + 32'(s * 4);
      end
      mis  = d_valid && ((taken != d_pred_taken) || (taken && (d_pred_target != tgt)));
      e.fl = exc_req || eret_req || mis;
      sbq.push_back(e);
      if (reset) return;

      if (exc_req)        nxt = EXC_PC;
      else if (eret_req)  nxt = epc;
      else if (mis)       nxt = taken ? tgt : d_pc + 32'd4;
      else if (stall_i)   nxt = m_pc;
      else if (e.pt)      nxt = e.ptgt;
      else                nxt = m_pc + 32'd4;

      if (d_valid && (d_type != 3'd0)) begin
         if (taken) begin
            m_vld[slot(d_pc)]  = 1'b1;
            m_word[slot(d_pc)] = d_pc[31:2];
            m_tgt[slot(d_pc)]  = tgt;
         end else if (m_hit(d_pc)) begin
            m_vld[slot(d_pc)] = 1'b0;
         end
         if (m_br < 64'h0000_0000_FFFF_FFFF) m_br++;
      end
      if (mis && (m_mis < 64'h0000_0000_FFFF_FFFF)) m_mis++;
      m_pc = nxt;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: outputs are combinational on inputs driven at negedge, sampled 1ns later
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pc_o",          64'(pc_o),          64'(e.pc));
            chk("pred_taken_o",  64'(pred_taken_o),  64'(e.pt));
            chk("pred_target_o", 64'(pred_target_o), 64'(e.ptgt));
            chk("flush_o",       64'(flush_o),       64'(e.fl));
`ifdef PC_PERF_CNT_EN
            chk("br_cnt_o",      64'(br_cnt_o),      64'(e.bc));
            chk("mispred_cnt_o", 64'(mispred_cnt_o), 64'(e.mc));
`endif
         end
      end
   end

   task automatic idle();
      stall_i       = 1'b0;
      d_valid       = 1'b0;
      d_type        = 3'd0;
      d_pred_taken  = 1'b0;
      d_pred_target = '0;
      exc_req       = 1'b0;
      eret_req      = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      idle();
   endtask

   task automatic d_instr(logic [2:0] t, logic [31:0] pc, logic [25:0] i26, logic [15:0] i16,
                          logic z, logic pt, logic [31:0] ptgt);
      d_valid = 1'b1; d_type = t; d_pc = pc; d_imm26 = i26; d_imm16 = i16;
      d_zero = z; d_pred_taken = pt; d_pred_target = ptgt;
   endtask

   task automatic eret_to(logic [31:0] a);
      step(); eret_req = 1'b1; epc = a; apply();
   endtask

   initial begin
      int r;
      // Reset held, then released: sequential fetch from RESET_PC
      step(); apply();
      step(); reset = 1'b0; apply();
      repeat (3) begin step(); apply(); end

      // Cold jump redirects and trains the BTB; refetch then predicts
      step(); d_instr(3'd1, 32'h3000, 26'h0000C10, 16'h0, 1'b0, 1'b0, 32'h0); apply();
      eret_to(32'h3000);
      step(); apply();
      step(); apply();

      // beq to itself: correct prediction, then a not-taken mispredict invalidates
      step(); d_instr(3'd3, 32'h3010, 26'h0, 16'hFFFF, 1'b1, 1'b1, 32'h3010); apply();
      step(); d_instr(3'd3, 32'h3010, 26'h0, 16'hFFFF, 1'b0, 1'b1, 32'h3010); apply();
      eret_to(32'h3010);
      step(); apply();

      // Exception beats stall and a concurrent mispredict; then ERET
      step(); stall_i = 1'b1; exc_req = 1'b1;
      d_instr(3'd1, 32'h3000, 26'h0000C20, 16'h0, 1'b0, 1'b0, 32'h0); apply();
      eret_to(32'h3020);
      step(); apply();

      // Aliasing branches share one slot; the older one loses its entry
      step(); d_instr(3'd2, 32'h3020, 26'h0, 16'h0, 1'b0, 1'b0, 32'h0); d_reg = 32'h3100; apply();
      eret_to(32'h3000);
      step(); apply();

      // Sequential wrap past the top of the address space
      eret_to(32'hFFFF_FFFC);
      step(); apply();
      step(); apply();

      // Randomised traffic with a mid-run asynchronous reset
      for (int n = 0; n < 400; n++) begin
         step();
         if (n == 200) begin
            reset = 1'b1; apply();
            step(); reset = 1'b0;
         end
         stall_i = ($urandom_range(0, 4) == 0);
         d_valid = ($urandom_range(0, 9) < 6);
         d_type  = 3'($urandom_range(0, 3));
         d_pc    = RST_PC + 32'(4 * $urandom_range(0, 31));
         d_imm26 = 26'((RST_PC + 32'(4 * $urandom_range(0, 31))) >> 2);
         r       = int'($urandom_range(0, 15)) - 8;
         d_imm16 = 16'(r);
         d_reg   = RST_PC + 32'(4 * $urandom_range(0, 31));
         d_zero  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            d_pred_taken  = m_hit(d_pc);
            d_pred_target = d_pred_taken ? m_tgt[slot(d_pc)] : 32'h0;
         end else begin
            d_pred_taken  = 1'($urandom_range(0, 1));
            d_pred_target = RST_PC + 32'(4 * $urandom_range(0, 31));
         end
         exc_req  = ($urandom_range(0, 29) == 0);
         eret_req = ($urandom_range(0, 19) == 0);
         epc      = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                                 : RST_PC + 32'(4 * $urandom_range(0, 31));
         apply();
      end

      step();
      repeat (3) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
      end
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
